// File: rtl/hack_ram_banked.sv
// Banked word RAM with a hardware clear engine that zeroes every word after reset or on clr.
// Optional HACK_RAM_READ_REG_EN: registered read with one-cycle latency instead of a combinational read.
module hack_ram_banked #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned BANK_BITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  in,
  input  logic [ADDR_W-1:0] addr,
  input  logic              load,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = ADDR_W - BANK_BITS;
  localparam int unsigned NBANKS = 1 << BANK_BITS;
  localparam int unsigned NWORDS = 1 << WORD_W;
  localparam int unsigned BANK_W = (BANK_BITS > 0) ? BANK_BITS : 1;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t              state, state_n;
  logic [WORD_W-1:0]   cnt, cnt_n;
  logic                busy_n, done_n;
  logic                wipe_c;
  logic [NBANKS-1:0]   bank_we_c;
  logic [BANK_W-1:0]   bank_sel;
  logic [WORD_W-1:0]   word_sel;
  logic [WIDTH-1:0]    mem [NBANKS][NWORDS];

  // Upper address bits pick the bank, lower bits the word inside it.
  assign bank_sel = BANK_W'(addr >> WORD_W);
  assign word_sel = addr[WORD_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLEAR;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
    end
  end

  // Sweep sequencing; clr restarts a sweep and always wins over load.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    busy_n    = busy;
    done_n    = 1'b0;
    wipe_c    = 1'b0;
    bank_we_c = '0;
    case (state)
      CLEAR: begin
        wipe_c = 1'b1;
        if (clr) begin
          cnt_n = '0;
        end else if (cnt == WORD_W'(NWORDS - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + WORD_W'(1);
        end
      end
      IDLE: begin
        if (clr) begin
          state_n = CLEAR;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end else if (load) begin
          bank_we_c[bank_sel] = 1'b1;
        end
      end
      default: begin
        state_n = CLEAR;
        cnt_n   = '0;
        busy_n  = 1'b1;
      end
    endcase
  end

  // Storage is never reset; the sweep wipes word cnt in every bank at once.
  always_ff @(posedge clk) begin
    for (int unsigned b = 0; b < NBANKS; b++) begin
      if (wipe_c) begin
        mem[BANK_W'(b)][cnt] <= '0;
      end else if (bank_we_c[BANK_W'(b)]) begin
        mem[BANK_W'(b)][word_sel] <= in;
      end
    end
  end

`ifdef HACK_RAM_READ_REG_EN
  // Read-before-write register; blanked on any edge taken while sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out <= '0;
    end else if (busy) begin
      out <= '0;
    end else begin
      out <= mem[bank_sel][word_sel];
    end
  end
`else
  assign out = busy ? '0 : mem[bank_sel][word_sel];
`endif

endmodule

// File: tb/tb_hack_ram_banked.sv
// Self-checking bench for hack_ram_banked: a flat-array model checked every cycle plus literal expectations.
module tb_hack_ram_banked;

  localparam int unsigned NW    = 8;
  localparam int unsigned DEPTH = 64;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [15:0] in    = '0;
  logic [5:0]  addr  = '0;
  logic        load  = 1'b0;
  logic        clr   = 1'b0;
  logic [15:0] out;
  logic        busy;
  logic        done;

  hack_ram_banked #(.WIDTH(16), .ADDR_W(6), .BANK_BITS(3)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .in   (in),
    .addr (addr),
    .load (load),
    .clr  (clr),
    .out  (out),
    .busy (busy),
    .done (done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Flat model: address a lives in bank a/8, word a%8; rem = sweep edges still to come.
  logic [15:0] mem_m [DEPTH] = '{default: 16'h0000};
  int          rem    = NW;
  logic        m_done = 1'b0;
  logic [15:0] m_out  = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem    = NW;
      m_done = 1'b0;
      m_out  = '0;
    end else begin
      m_out  = (rem > 0) ? 16'h0000 : mem_m[addr];
      m_done = 1'b0;
      if (clr) begin
        rem = NW;
      end else if (rem > 0) begin
        for (int b = 0; b < 8; b++) mem_m[b * NW + (NW - rem)] = 16'h0000;
        rem = rem - 1;
        if (rem == 0) m_done = 1'b1;
      end else if (load) begin
        mem_m[addr] = in;
      end
    end
  end

  function automatic logic [15:0] exp_out();
`ifdef HACK_RAM_READ_REG_EN
    return m_out;
`else
    return (rem > 0) ? 16'h0000 : mem_m[addr];
`endif
  endfunction

  bit          check_en = 1'b0;
  bit          lit_en   = 1'b0;
  int          lit_sel  = 0;
  logic [15:0] lit_exp  = '0;
  string       lit_name = "";

  function automatic logic [15:0] lit_val();
    case (lit_sel)
      0:       return out;
      1:       return 16'(busy);
      default: return 16'(done);
    endcase
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("busy", 16'(busy), 16'(rem > 0));
      chk("done", 16'(done), 16'(m_done));
      chk("out", out, exp_out());
      if (lit_en) chk(lit_name, lit_val(), lit_exp);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string n, input int sel, input logic [15:0] e);
    lit_name = n;
    lit_sel  = sel;
    lit_exp  = e;
    lit_en   = 1'b1;
    @(negedge clk);
    #1;
    lit_en   = 1'b0;
  endtask

  task automatic wr(input logic [5:0] a, input logic [15:0] d);
    addr = a;
    in   = d;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, input logic [15:0] e, input string n);
    addr = a;
    tick();
    lit(n, 0, e);
  endtask

  initial begin
    #2;
    rst_n    = 1'b0;
    check_en = 1'b1;
    lit("rst_busy", 1, 16'h0001);
    lit("rst_out", 0, 16'h0000);
    lit("rst_done", 2, 16'h0000);
    tick();
    rst_n = 1'b1;

    // Power-up sweep: busy for exactly 8 edges, one-cycle done.
    repeat (7) tick();
    lit("sweep_busy7", 1, 16'h0001);
    tick();
    lit("sweep_done", 2, 16'h0001);
    lit("sweep_idle", 1, 16'h0000);
    lit("sweep_done_drop", 2, 16'h0000);
    for (int i = 0; i < DEPTH; i++) begin
      addr = 6'(i);
      tick();
    end
    rd(6'd63, 16'h0000, "sweep_a63");

    // Bank and word isolation.
    wr(6'd0, 16'h1234);
    wr(6'd9, 16'hBEEF);
    wr(6'd63, 16'hFFFF);
    rd(6'd0, 16'h1234, "rd_a0");
    rd(6'd9, 16'hBEEF, "rd_a9");
    rd(6'd63, 16'hFFFF, "rd_a63");
    rd(6'd1, 16'h0000, "rd_a1");
    rd(6'd8, 16'h0000, "rd_a8");
    rd(6'd62, 16'h0000, "rd_a62");

    // Read during write at one address.
`ifdef HACK_RAM_READ_REG_EN
    wr(6'd7, 16'h00FF);
    addr = 6'd7;
    tick();
    lit("rreg_lat1", 0, 16'h00FF);
    in   = 16'h0F0F;
    load = 1'b1;
    tick();
    load = 1'b0;
    lit("rreg_rbw_old", 0, 16'h00FF);
    tick();
    lit("rreg_rbw_new", 0, 16'h0F0F);
`else
    wr(6'd7, 16'h00FF);
    addr = 6'd7;
    in   = 16'h0F0F;
    load = 1'b1;
    lit("rdw_old", 0, 16'h00FF);
    tick();
    load = 1'b0;
    lit("rdw_new", 0, 16'h0F0F);
`endif

    // clr and load on the same edge: write dropped, full sweep follows.
    addr = 6'd3;
    in   = 16'h5555;
    clr  = 1'b1;
    load = 1'b1;
    tick();
    clr  = 1'b0;
    load = 1'b0;
    repeat (7) tick();
    lit("clr_busy7", 1, 16'h0001);
    tick();
    lit("clr_done", 2, 16'h0001);
    rd(6'd3, 16'h0000, "clr_no_write");
    rd(6'd9, 16'h0000, "clr_wiped_a9");

    // Reset mid-read forces out low at once; load during the sweep is ignored.
    wr(6'd5, 16'h1357);
    addr = 6'd5;
    tick();
    rst_n = 1'b0;
    lit("rst_mid_out", 0, 16'h0000);
    tick();
    rst_n = 1'b1;
    in    = 16'hAAAA;
    load  = 1'b1;
    lit("busy_out0", 0, 16'h0000);
    repeat (7) tick();
    load = 1'b0;
    rd(6'd5, 16'h0000, "load_busy_drop");

    // clr at sweep cycle 4 restarts; a single done at the end.
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (3) tick();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    repeat (7) tick();
    lit("restart_busy", 1, 16'h0001);
    tick();
    lit("restart_done", 2, 16'h0001);
    lit("restart_done_drop", 2, 16'h0000);

    // A scatter of writes, then a full read sweep against the model.
    for (int i = 0; i < 8; i++) wr(6'(i * 9 + 2), 16'(16'h1111 * (i + 1)));
    for (int i = 0; i < DEPTH; i++) begin
      addr = 6'(i);
      tick();
    end
    rd(6'd2, 16'h1111, "scatter_a2");
    rd(6'd65 - 6'd0, 16'h8888, "scatter_a1");
    tick();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
